xif_mem_obi_bridge: RTL and testbench

Core-side responder for the eXtension-interface memory channel: accepts load/store requests issued by an offloading coprocessor (e.g. the FPU subsystem's flw/fsw), checks alignment, gates speculative requests on commit, runs one OBI data-bus transaction and returns the memory result. It sits in the core complex between the coprocessor's x_mem port and the data-side OBI master mux. One transaction is outstanding at a time.

---
 rtl/xif_mem_obi_bridge_pkg.sv | 64 ++++++
 rtl/xif_mem_obi_bridge.sv | 161 ++++++++++++++++
 tb/tb_xif_mem_obi_bridge.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xif_mem_obi_bridge_pkg.sv
// Shared XIF memory-channel types, exception codes and lane helpers.
package xif_mem_obi_bridge_pkg;

  localparam int unsigned XIF_ID_W = 4;

  localparam logic [5:0] EXC_LOAD_MISALIGNED  = 6'd4;
  localparam logic [5:0] EXC_STORE_MISALIGNED = 6'd6;

  typedef struct packed {
    logic [XIF_ID_W-1:0] id;
    logic [31:0]         addr;
    logic [1:0]          mode;
    logic                we;
    logic [1:0]          size;
    logic [31:0]         wdata;
    logic                last;
    logic                spec;
  } x_mem_req_t;

  typedef struct packed {
    logic       exc;
    logic [5:0] exccode;
    logic       dbg;
  } x_mem_resp_t;

  typedef struct packed {
    logic [XIF_ID_W-1:0] id;
    logic [31:0]         rdata;
    logic                err;
    logic                dbg;
  } x_mem_result_t;

  typedef struct packed {
    logic [XIF_ID_W-1:0] id;
    logic                commit_kill;
  } x_commit_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_COMMIT,
    ST_REQ,
    ST_RSP
  } state_e;

  // Access does not fit in its natural alignment; size 3 (8 bytes) never fits a 32-bit bus.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = off[0];
      2'd2:    misaligned = (off != 2'd0);
      default: misaligned = 1'b1;
    endcase
  endfunction

  // Byte enables for an aligned access placed at byte lane 'off'.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    lane_be = 4'b0001 << off;
      2'd1:    lane_be = 4'b0011 << off;
      default: lane_be = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/xif_mem_obi_bridge.sv
// XIF memory-channel responder: alignment check, commit gating and a single
// outstanding OBI transaction per request, with a registered result strobe.
module xif_mem_obi_bridge
  import xif_mem_obi_bridge_pkg::*;
#(
  parameter int unsigned X_ID_WIDTH = XIF_ID_W,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    x_mem_valid_i,
  output logic                    x_mem_ready_o,
  input  x_mem_req_t              x_mem_req_i,
  output x_mem_resp_t             x_mem_resp_o,
  output logic                    x_mem_result_valid_o,
  output x_mem_result_t           x_mem_result_o,
  input  logic                    x_commit_valid_i,
  input  x_commit_t               x_commit_i,
  output logic                    data_req_o,
  input  logic                    data_gnt_i,
  output logic [31:0]             data_addr_o,
  output logic                    data_we_o,
  output logic [DATA_WIDTH/8-1:0] data_be_o,
  output logic [DATA_WIDTH-1:0]   data_wdata_o,
  input  logic                    data_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   data_rdata_i,
  input  logic                    data_err_i
);

  localparam int unsigned NUM_IDS = 2**X_ID_WIDTH;

  state_e              state_q, state_d;
  x_mem_req_t          req_q;
  logic [NUM_IDS-1:0]  committed_q, killed_q;
  x_mem_result_t       result_q;
  logic                result_valid_q;

  logic req_misaligned, load_req, drop, done;
  logic cmt_hit, lat_killed, lat_committed;
  logic unused_ok;

  assign req_misaligned = misaligned(x_mem_req_i.size, x_mem_req_i.addr[1:0]);

  // Commit state for the latched id, including a strobe arriving this cycle.
  assign cmt_hit       = x_commit_valid_i && (x_commit_i.id == req_q.id);
  assign lat_killed    = killed_q[req_q.id] || (cmt_hit && x_commit_i.commit_kill);
  assign lat_committed = committed_q[req_q.id] || (cmt_hit && !x_commit_i.commit_kill);

  // Next-state and handshake decode.
  always_comb begin
    state_d       = state_q;
    x_mem_ready_o = 1'b0;
    data_req_o    = 1'b0;
    load_req      = 1'b0;
    drop          = 1'b0;
    done          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        x_mem_ready_o = 1'b1;
        if (x_mem_valid_i && !req_misaligned) begin
          load_req = 1'b1;
          state_d  = x_mem_req_i.spec ? ST_WAIT_COMMIT : ST_REQ;
        end
      end
      ST_WAIT_COMMIT: begin
        if (lat_killed) begin
          drop    = 1'b1;
          state_d = ST_IDLE;
        end else if (lat_committed) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        data_req_o = 1'b1;
        if (data_gnt_i) state_d = ST_RSP;
      end
      ST_RSP: begin
        if (data_rvalid_i) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Latch the accepted request; it drives the bus fields until completion.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       req_q <= '0;
    else if (load_req) req_q <= x_mem_req_i;
  end

  // Commit/kill tracking. A strobe consumed by the finishing request itself is
  // not recorded, otherwise it would resurrect the bit that is being cleared.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      committed_q <= '0;
      killed_q    <= '0;
    end else begin
      if (drop || done) begin
        committed_q[req_q.id] <= 1'b0;
        killed_q[req_q.id]    <= 1'b0;
      end
      if (x_commit_valid_i && !((drop || done) && cmt_hit)) begin
        if (x_commit_i.commit_kill) killed_q[x_commit_i.id]    <= 1'b1;
        else                        committed_q[x_commit_i.id] <= 1'b1;
      end
    end
  end

  // Immediate exception response for misaligned requests, zero otherwise.
  always_comb begin
    x_mem_resp_o = '0;
    if (state_q == ST_IDLE && x_mem_valid_i && req_misaligned) begin
      x_mem_resp_o.exc     = 1'b1;
      x_mem_resp_o.exccode = x_mem_req_i.we ? EXC_STORE_MISALIGNED : EXC_LOAD_MISALIGNED;
    end
  end

  // Bus fields are only driven during the request phase, zero otherwise.
  always_comb begin
    data_addr_o  = '0;
    data_we_o    = 1'b0;
    data_be_o    = '0;
    data_wdata_o = '0;
    if (data_req_o) begin
      data_addr_o = {req_q.addr[31:2], 2'b00};
      data_we_o   = req_q.we;
      data_be_o   = lane_be(req_q.size, req_q.addr[1:0]);
      if (req_q.we) data_wdata_o = req_q.wdata << {req_q.addr[1:0], 3'b000};
    end
  end

  // Result strobe one cycle after rvalid; loads are lane-shifted down, stores return zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_valid_q <= 1'b0;
      result_q       <= '0;
    end else begin
      result_valid_q <= done;
      if (done) begin
        result_q.id    <= req_q.id;
        result_q.rdata <= req_q.we ? '0 : (data_rdata_i >> {req_q.addr[1:0], 3'b000});
        result_q.err   <= data_err_i;
        result_q.dbg   <= 1'b0;
      end
    end
  end

  assign x_mem_result_valid_o = result_valid_q;
  assign x_mem_result_o       = result_q;

  assign unused_ok = ^{req_q.mode, req_q.last, req_q.spec};

endmodule

// File: tb/tb_xif_mem_obi_bridge.sv
// Randomized bench for xif_mem_obi_bridge: the driver derives every expected
// output from transaction-level rules; one negedge process compares.
module tb_xif_mem_obi_bridge;
  import xif_mem_obi_bridge_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          x_mem_valid_i;
  logic          x_mem_ready_o;
  x_mem_req_t    x_mem_req_i;
  x_mem_resp_t   x_mem_resp_o;
  logic          x_mem_result_valid_o;
  x_mem_result_t x_mem_result_o;
  logic          x_commit_valid_i;
  x_commit_t     x_commit_i;
  logic          data_req_o, data_gnt_i, data_we_o;
  logic [31:0]   data_addr_o, data_wdata_o, data_rdata_i;
  logic [3:0]    data_be_o;
  logic          data_rvalid_i, data_err_i;

  xif_mem_obi_bridge dut (
    .clk_i(clk), .rst_ni(rst_n),
    .x_mem_valid_i(x_mem_valid_i), .x_mem_ready_o(x_mem_ready_o),
    .x_mem_req_i(x_mem_req_i), .x_mem_resp_o(x_mem_resp_o),
    .x_mem_result_valid_o(x_mem_result_valid_o), .x_mem_result_o(x_mem_result_o),
    .x_commit_valid_i(x_commit_valid_i), .x_commit_i(x_commit_i),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  int req_cnt = 0, res_cnt = 0, t_acc = 0, t_res = 0;

  // Expected outputs for the current cycle, set by the driver.
  logic        e_ready = 1'b1, e_req = 1'b0, e_rv = 1'b0, e_resp_chk = 1'b0;
  logic        e_exc, e_we, e_err;
  logic [5:0]  e_code;
  logic [3:0]  e_be, e_id;
  logic [31:0] e_addr, e_wdata, e_rdata;

  // Values captured from the DUT for the literal checks.
  logic        cap_exc, cap_err;
  logic [5:0]  cap_code;
  logic [3:0]  cap_be;
  logic [31:0] cap_addr, cap_wdata, cap_rdata;

  // Commit bookkeeping of the reference model.
  bit m_comm[16];
  bit m_kill[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---- reference model: byte-lane arithmetic ----
  function automatic bit m_mis(input logic [1:0] sz, input logic [31:0] a);
    int nb;
    if (sz == 2'd3) return 1'b1;
    nb = 1 << sz;
    return (a % nb) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    int off, nb;
    logic [3:0] be;
    off = int'(a % 4);
    nb  = 1 << sz;
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + nb);
    return be;
  endfunction

  function automatic logic [31:0] m_wd(input logic [31:0] wd, input logic [31:0] a);
    int off;
    logic [31:0] res;
    off = int'(a % 4);
    res = '0;
    for (int i = 0; i < 4; i++) if (i >= off) res[8*i +: 8] = wd[8*(i-off) +: 8];
    return res;
  endfunction

  function automatic logic [31:0] m_rd(input logic [31:0] rd, input logic [31:0] a);
    int off;
    logic [31:0] res;
    off = int'(a % 4);
    res = '0;
    for (int i = 0; i < 4; i++) if (i + off < 4) res[8*i +: 8] = rd[8*(i+off) +: 8];
    return res;
  endfunction

  // ---- compare process ----
  always @(negedge clk) begin
    chk("ready", x_mem_ready_o, e_ready);
    chk("data_req", data_req_o, e_req);
    chk("result_valid", x_mem_result_valid_o, e_rv);
    if (data_req_o) req_cnt++;
    if (x_mem_result_valid_o) begin res_cnt++; t_res = cyc; end
    if (e_resp_chk) begin
      chk("resp_exc", x_mem_resp_o.exc, e_exc);
      chk("resp_exccode", x_mem_resp_o.exccode, e_code);
      chk("resp_dbg", x_mem_resp_o.dbg, 1'b0);
      cap_exc = x_mem_resp_o.exc; cap_code = x_mem_resp_o.exccode;
    end
    if (e_req) begin
      chk("data_addr", data_addr_o, e_addr);
      chk("data_be", data_be_o, e_be);
      chk("data_we", data_we_o, e_we);
      if (e_we) chk("data_wdata", data_wdata_o, e_wdata);
      cap_addr = data_addr_o; cap_be = data_be_o; cap_wdata = data_wdata_o;
    end
    if (e_rv) begin
      chk("result_id", x_mem_result_o.id, e_id);
      chk("result_rdata", x_mem_result_o.rdata, e_rdata);
      chk("result_err", x_mem_result_o.err, e_err);
      chk("result_dbg", x_mem_result_o.dbg, 1'b0);
      cap_rdata = x_mem_result_o.rdata; cap_err = x_mem_result_o.err;
    end
  end

  // ---- driver ----
  task automatic step();
    @(posedge clk); #1;
    x_mem_valid_i = 1'b0; x_commit_valid_i = 1'b0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    e_resp_chk = 1'b0;
  endtask

  task automatic idle_cycle();
    step();
    e_ready = 1'b1; e_req = 1'b0; e_rv = 1'b0;
  endtask

  task automatic set_req_exp(input x_mem_req_t r);
    e_req = 1'b1; e_ready = 1'b0;
    e_addr = {r.addr[31:2], 2'b00};
    e_be = m_be(r.size, r.addr);
    e_we = r.we;
    e_wdata = m_wd(r.wdata, r.addr);
  endtask

  task automatic stray(input logic [3:0] id, input bit kill);
    idle_cycle();
    x_commit_valid_i = 1'b1; x_commit_i.id = id; x_commit_i.commit_kill = kill;
    if (kill) m_kill[id] = 1'b1; else m_comm[id] = 1'b1;
  endtask

  task automatic run_txn(input x_mem_req_t r, input int wait_n, input bit kill,
                         input int gdly, input int rdly, input logic [31:0] rd, input bit er);
    bit mis;
    step();
    e_rv = 1'b0; e_ready = 1'b1; e_req = 1'b0;
    x_mem_valid_i = 1'b1; x_mem_req_i = r; t_acc = cyc;
    mis = m_mis(r.size, r.addr);
    e_resp_chk = 1'b1; e_exc = mis;
    e_code = mis ? (r.we ? 6'd6 : 6'd4) : 6'd0;
    if (mis) begin
      step();
      return;
    end
    if (r.spec) begin
      step();
      e_ready = 1'b0;
      if (m_kill[r.id]) begin
        m_kill[r.id] = 1'b0; m_comm[r.id] = 1'b0;
        step(); e_ready = 1'b1;
        return;
      end
      if (!m_comm[r.id]) begin
        for (int i = 0; i < wait_n; i++) step();
        x_commit_valid_i = 1'b1; x_commit_i.id = r.id; x_commit_i.commit_kill = kill;
        if (kill) begin
          m_comm[r.id] = 1'b0;
          step(); e_ready = 1'b1;
          return;
        end
      end
    end
    step();
    set_req_exp(r);
    for (int i = 0; i <= gdly; i++) begin
      if (i > 0) step();
      data_gnt_i = (i == gdly);
    end
    step();
    e_req = 1'b0;
    for (int i = 0; i <= rdly; i++) begin
      if (i > 0) step();
      data_rdata_i = $urandom;
      if (i == rdly) begin
        data_rvalid_i = 1'b1; data_rdata_i = rd; data_err_i = er;
      end
    end
    step();
    data_err_i = 1'b0;
    e_ready = 1'b1; e_rv = 1'b1; e_id = r.id; e_err = er;
    e_rdata = r.we ? 32'h0 : m_rd(rd, r.addr);
    m_comm[r.id] = 1'b0; m_kill[r.id] = 1'b0;
  endtask

  function automatic x_mem_req_t mk(input logic [3:0] id, input logic [31:0] a, input logic [1:0] sz,
                                    input logic we, input logic [31:0] wd, input logic spec);
    x_mem_req_t r;
    r = '0;
    r.id = id; r.addr = a; r.size = sz; r.we = we; r.wdata = wd; r.spec = spec;
    return r;
  endfunction

  initial begin
    int rc, qc;
    x_mem_req_t r;
    rst_n = 1'b0;
    x_mem_valid_i = 1'b0; x_mem_req_i = '0;
    x_commit_valid_i = 1'b0; x_commit_i = '0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0; data_err_i = 1'b0;
    #1;
    chk("rst_ready", x_mem_ready_o, 1'b1);
    chk("rst_data_req", data_req_o, 1'b0);
    chk("rst_addr", data_addr_o, 32'h0);
    chk("rst_be", data_be_o, 4'h0);
    chk("rst_result_valid", x_mem_result_valid_o, 1'b0);
    idle_cycle(); idle_cycle();
    rst_n = 1'b1;
    idle_cycle();

    // Non-spec word load, immediate gnt/rvalid.
    run_txn(mk(4'd3, 32'h1000, 2'd2, 1'b0, 32'h0, 1'b0), 0, 0, 0, 0, 32'hDEADBEEF, 1'b0);
    idle_cycle();
    chk("lw_latency", t_res - t_acc, 3);
    chk("lw_rdata", cap_rdata, 32'hDEADBEEF);
    chk("lw_err", cap_err, 1'b0);

    // Byte store to the top lane.
    run_txn(mk(4'd1, 32'h1003, 2'd0, 1'b1, 32'h000000AB, 1'b0), 0, 0, 0, 0, 32'h12345678, 1'b0);
    idle_cycle();
    chk("sb_be", cap_be, 4'b1000);
    chk("sb_wdata", cap_wdata, 32'hAB000000);
    chk("sb_addr", cap_addr, 32'h1000);
    chk("sb_rdata", cap_rdata, 32'h0);

    // Misaligned word load: exception only.
    rc = res_cnt; qc = req_cnt;
    run_txn(mk(4'd2, 32'h1002, 2'd2, 1'b0, 32'h0, 1'b0), 0, 0, 0, 0, 32'h0, 1'b0);
    idle_cycle(); idle_cycle();
    chk("mis_exc", cap_exc, 1'b1);
    chk("mis_code", cap_code, 6'd4);
    chk("mis_no_req", req_cnt, qc);
    chk("mis_no_result", res_cnt, rc);

    // Speculative id 5 killed two cycles after acceptance.
    run_txn(mk(4'd5, 32'h3000, 2'd2, 1'b0, 32'h0, 1'b1), 1, 1, 0, 0, 32'h0, 1'b0);
    idle_cycle(); idle_cycle();
    chk("kill_no_req", req_cnt, qc);
    chk("kill_no_result", res_cnt, rc);

    // Commit recorded before the speculative request arrives.
    stray(4'd5, 1'b0);
    idle_cycle();
    run_txn(mk(4'd5, 32'h3004, 2'd2, 1'b0, 32'h0, 1'b1), 3, 0, 0, 0, 32'h0BADF00D, 1'b0);
    idle_cycle();
    chk("precommit_latency", t_res - t_acc, 4);

    // Slow grant, bus error on a halfword load.
    run_txn(mk(4'd9, 32'h2002, 2'd1, 1'b0, 32'h0, 1'b0), 0, 0, 4, 1, 32'hCAFEF00D, 1'b1);
    idle_cycle();
    chk("err_be", cap_be, 4'b1100);
    chk("err_addr", cap_addr, 32'h2000);
    chk("err_flag", cap_err, 1'b1);
    chk("err_rdata", cap_rdata, 32'h0000CAFE);

    // Reset while waiting for rvalid.
    rc = res_cnt;
    r = mk(4'd7, 32'h4000, 2'd2, 1'b0, 32'h0, 1'b0);
    step(); e_ready = 1'b1; e_req = 1'b0; e_rv = 1'b0;
    x_mem_valid_i = 1'b1; x_mem_req_i = r;
    e_resp_chk = 1'b1; e_exc = 1'b0; e_code = 6'd0;
    step(); set_req_exp(r); data_gnt_i = 1'b1;
    step(); e_req = 1'b0;
    step(); rst_n = 1'b0; e_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin m_comm[i] = 1'b0; m_kill[i] = 1'b0; end
    #1;
    chk("rst_mid_req", data_req_o, 1'b0);
    chk("rst_mid_ready", x_mem_ready_o, 1'b1);
    idle_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) idle_cycle();
    chk("rst_no_result", res_cnt, rc);

    // Randomized traffic.
    for (int t = 0; t < 250; t++) begin
      logic [1:0] sz;
      logic [31:0] a;
      if ($urandom_range(0, 3) == 0) stray(4'($urandom_range(0, 15)), $urandom_range(0, 2) == 0);
      sz = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 15) == 0) sz = 2'd3;
      a = $urandom;
      if ($urandom_range(0, 4) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      r = mk(4'($urandom_range(0, 15)), a, sz, 1'($urandom_range(0, 1)), $urandom,
             1'($urandom_range(0, 1)));
      r.mode = 2'($urandom_range(0, 3));
      r.last = 1'($urandom_range(0, 1));
      run_txn(r, $urandom_range(0, 3), $urandom_range(0, 2) == 0, $urandom_range(0, 4),
              $urandom_range(0, 3), $urandom, $urandom_range(0, 5) == 0);
      idle_cycle();
    end
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
